shift_issue_stage: RTL and testbench

- Registered issue/retire stage wrapped around the combinational 32-bit barrel shifter.
- Accepts shift requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives the FIFO head onto the shifter inputs (SH_DIR, SH_AMT, D_IN), then captures D_OUT into a response register with its own valid/ready handshake.
- Gives the combinational shifter a clean registered boundary and back-pressure on both sides.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_req_fifo.sv | 60 ++++++
 rtl/shift_issue_stage.sv | 113 +++++++++++
 tb/tb_shift_issue_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift issue stage and its request FIFO.
package shift_pkg;

    localparam int   DATA_W    = 32;
    localparam int   AMT_W     = 5;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Shift operation fields; the tag is added by the stage, whose width is a module parameter.
    typedef struct packed {
        logic              dir;
        logic [AMT_W-1:0]  amt;
        logic [DATA_W-1:0] data;
    } shift_op_t;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shift_req_fifo.sv
// DEPTH-entry synchronous FIFO of shift requests with a registered-storage head output.
module shift_req_fifo
    import shift_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  entry_t                  data_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [occ_w(DEPTH)-1:0] count_o,
    output entry_t                  head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = occ_w(DEPTH);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   count_q, count_d;

    assign full_o  = (count_q == OCC_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        count_d  = count_q + OCC_W'(push_i) - OCC_W'(pop_i);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    a_no_push_full:  assert property (@(posedge CLK) disable iff (RST) !(push_i && full_o));
    a_no_pop_empty:  assert property (@(posedge CLK) disable iff (RST) !(pop_i && empty_o));

endmodule

// File: rtl/shift_issue_stage.sv
// Registered issue/retire stage around an external combinational barrel shifter:
// request FIFO feeds the shifter, the result is captured into a handshaked response register.
module shift_issue_stage
    import shift_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         REQ_VALID,
    output logic                         REQ_READY,
    input  logic                         REQ_DIR,
    input  logic [AMT_W-1:0]             REQ_AMT,
    input  logic [DATA_W-1:0]            REQ_DATA,
    input  logic [TAG_W-1:0]             REQ_TAG,
    output logic                         SH_DIR,
    output logic [AMT_W-1:0]             SH_AMT,
    output logic [DATA_W-1:0]            D_IN,
    input  logic [DATA_W-1:0]            D_OUT,
    output logic                         RSP_VALID,
    input  logic                         RSP_READY,
    output logic [DATA_W-1:0]            RSP_DATA,
    output logic [TAG_W-1:0]             RSP_TAG,
    output logic                         RSP_ZERO,
    output logic [$clog2(DEPTH+1)-1:0]   OCC
);

    typedef struct packed {
        shift_op_t        op;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t                req_in, head;
    logic                fifo_full, fifo_empty, push, fire;
    logic                rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
    logic                rsp_zero_q, rsp_zero_d;

    always_comb begin
        req_in.op.dir  = REQ_DIR;
        req_in.op.amt  = REQ_AMT;
        req_in.op.data = REQ_DATA;
        req_in.tag     = REQ_TAG;
    end

    // Ready comes from registered occupancy only: no push-through when full.
    assign REQ_READY = !fifo_full;
    assign push      = REQ_VALID && !fifo_full;
    assign fire      = !fifo_empty && (!rsp_vld_q || RSP_READY);

    shift_req_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (req_t)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (push),
        .pop_i   (fire),
        .data_i  (req_in),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (OCC),
        .head_o  (head)
    );

    // An idle shifter sees all-zero inputs rather than stale storage.
    always_comb begin
        SH_DIR = fifo_empty ? DIR_LEFT : head.op.dir;
        SH_AMT = fifo_empty ? '0       : head.op.amt;
        D_IN   = fifo_empty ? '0       : head.op.data;
    end

    always_comb begin
        rsp_vld_d  = rsp_vld_q;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_zero_d = rsp_zero_q;
        if (fire) begin
            rsp_vld_d  = 1'b1;
            rsp_data_d = D_OUT;
            rsp_tag_d  = head.tag;
            rsp_zero_d = (D_OUT == '0);
        end else if (RSP_READY) begin
            rsp_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    assign RSP_VALID = rsp_vld_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_TAG   = rsp_tag_q;
    assign RSP_ZERO  = rsp_zero_q;

    a_rsp_hold: assert property (@(posedge CLK) disable iff (RST)
        (rsp_vld_q && !RSP_READY) |=> (rsp_vld_q && $stable(rsp_data_q)
                                       && $stable(rsp_tag_q) && $stable(rsp_zero_q)));

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage: behavioural barrel shifter on SH_*/D_OUT, queue scoreboard, directed and random phases.
module tb_shift_issue_stage;
    import shift_pkg::*;

    logic        clk, rst;
    logic        req_valid, req_ready, req_dir;
    logic [4:0]  req_amt;
    logic [31:0] req_data;
    logic [3:0]  req_tag;
    logic        sh_dir;
    logic [4:0]  sh_amt;
    logic [31:0] d_in, d_out;
    logic        rsp_valid, rsp_ready, rsp_zero;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic [2:0]  occ;

    int total = 0;
    int bad   = 0;
    logic stream_mode = 1'b0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
    } exp_t;
    exp_t exp_q[$];

    shift_issue_stage #(.DEPTH(4), .TAG_W(4)) dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_DIR(req_dir),
        .REQ_AMT(req_amt), .REQ_DATA(req_data), .REQ_TAG(req_tag),
        .SH_DIR(sh_dir), .SH_AMT(sh_amt), .D_IN(d_in), .D_OUT(d_out),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
        .RSP_TAG(rsp_tag), .RSP_ZERO(rsp_zero), .OCC(occ)
    );

    // Stand-in for the external combinational barrel shifter.
    logic signed [31:0] d_in_s;
    logic        [31:0] sra_res;
    always_comb begin
        d_in_s  = d_in;
        sra_res = d_in_s >>> sh_amt;
        d_out   = sh_dir ? sra_res : (d_in << sh_amt);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference shift: one bit position at a time, sign bit replicated for right shifts.
    function automatic logic [31:0] ref_shift(input logic dir, input logic [4:0] amt, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        for (int i = 0; i < int'(amt); i++) begin
            if (dir == DIR_RIGHT) r = {r[31], r[31:1]};
            else                  r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    // Scoreboard: handshakes are observed at the negedge before the edge that acts on them.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                chk("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_tag",  32'(rsp_tag), 32'(e.tag));
                    chk("rsp_zero", 32'(rsp_zero), 32'(e.data == 32'd0));
                end
            end
            if (req_valid && req_ready) begin
                e.data = ref_shift(req_dir, req_amt, req_data);
                e.tag  = req_tag;
                exp_q.push_back(e);
            end
            if (stream_mode) chk("stream_occ_le1", 32'(occ <= 3'd1), 32'd1);
        end
    end

    // Starts and ends at posedge+1; leaves REQ_VALID high.
    task automatic push_req(input logic dir, input logic [4:0] amt, input logic [31:0] data, input logic [3:0] tag);
        req_dir = dir; req_amt = amt; req_data = data; req_tag = tag; req_valid = 1'b1;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (req_ready) break;
            @(posedge clk); #1;
        end
        chk("push_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic directed(input logic dir, input logic [4:0] amt, input logic [31:0] data,
                            input logic [3:0] tag, input logic [31:0] exp_data, input logic exp_zero);
        push_req(dir, amt, data, tag);
        req_valid = 1'b0;
        @(negedge clk);
        chk("lat_not_yet", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(rsp_valid), 32'd1);
        chk("dir_data",  rsp_data, exp_data);
        chk("dir_tag",   32'(rsp_tag), 32'(tag));
        chk("dir_zero",  32'(rsp_zero), 32'(exp_zero));
        @(posedge clk); #1;
    endtask

    initial begin
        int run, seen;
        logic done;
        rst = 1'b1; req_valid = 1'b0; req_dir = 1'b0; req_amt = '0; req_data = '0; req_tag = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_occ",       32'(occ), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_data",  rsp_data, 32'd0);
        chk("rst_rsp_tag",   32'(rsp_tag), 32'd0);
        chk("rst_rsp_zero",  32'(rsp_zero), 32'd0);
        @(posedge clk); #1;

        directed(1'b0, 5'd4,  32'h0000_00F1, 4'd3, 32'h0000_0F10, 1'b0);
        directed(1'b1, 5'd31, 32'h8000_0000, 4'd1, 32'hFFFF_FFFF, 1'b0);
        directed(1'b1, 5'd4,  32'h7000_0000, 4'd2, 32'h0700_0000, 1'b0);
        directed(1'b0, 5'd1,  32'h8000_0000, 4'd4, 32'h0000_0000, 1'b1);
        directed(1'b1, 5'd0,  32'hDEAD_BEEF, 4'd5, 32'hDEAD_BEEF, 1'b0);
        directed(1'b0, 5'd0,  32'h1234_5678, 4'd6, 32'h1234_5678, 1'b0);
        @(negedge clk);
        chk("idle_sh_dir", 32'(sh_dir), 32'd0);
        chk("idle_sh_amt", 32'(sh_amt), 32'd0);
        chk("idle_d_in",   d_in, 32'd0);
        @(posedge clk); #1;

        // Full and drain
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 4'(8 + i));
        req_data = 32'hFFFF_0000; req_tag = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_req_ready", 32'(req_ready), 32'd0);
            chk("full_occ",       32'(occ), 32'd4);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("drain0_req_ready", 32'(req_ready), 32'd0);
        chk("drain0_valid",     32'(rsp_valid), 32'd1);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            chk("drain_valid", 32'(rsp_valid), 32'd1);
            if (k == 1) chk("drain1_req_ready", 32'(req_ready), 32'd1);
        end
        @(negedge clk);
        chk("drain_end_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;

        // Streaming
        stream_mode = 1'b1;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    push_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 4'(i));
                req_valid = 1'b0;
            end
            begin
                for (int w = 0; w < 10 && !rsp_valid; w++) @(negedge clk);
                chk("stream_first", 32'(rsp_valid), 32'd1);
                run = 0;
                for (int c = 0; c < 20; c++) begin
                    if (rsp_valid) run++;
                    @(negedge clk);
                end
                chk("stream_run", 32'(run), 32'd20);
            end
        join
        stream_mode = 1'b0;
        @(posedge clk); #1;

        // Random back-pressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++)
                    push_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                             ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, 4'($urandom));
                req_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Reset mid-flight
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_req(1'b0, 5'(i + 1), 32'hA5A5_0000 + 32'(i), 4'(i));
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_occ",   32'(occ), 32'd3);
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid",     32'(rsp_valid), 32'd0);
        chk("mid_rst_occ",       32'(occ), 32'd0);
        chk("mid_rst_sh_amt",    32'(sh_amt), 32'd0);
        chk("mid_rst_d_in",      d_in, 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("no_stale_rsp", 32'(seen), 32'd0);
        @(posedge clk); #1;

        directed(1'b1, 5'd8, 32'h8000_1234, 4'd9, 32'hFF80_0012, 1'b0);
        repeat (3) @(posedge clk);
        chk("model_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
